// File: rtl/imem_wb_loader_pkg.sv
// Shared constants and FSM state type for the SLRV instruction-memory loader.
package slrv_imem_pkg;

  localparam int          IMEM_AW       = 9;
  localparam logic [15:0] SRAM_WIN_END  = 16'h07FF;
  localparam logic [15:0] CTRL_OFF      = 16'h1000;
  localparam logic [15:0] STATUS_OFF    = 16'h1004;
  localparam int          CTRL_HOLD_BIT = 0;
  localparam int          CTRL_CLR_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SRAM_ACC = 2'd1,
    RD_WAIT  = 2'd2,
    ACK      = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_wb_loader_if.sv
// Wishbone classic slave bus between the management core and the imem loader.
interface imem_wb_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/imem_wb_loader.sv
// Wishbone loader for the SLRV instruction SRAM port 0, with core-hold and write counter.
// Define IMEM_LOADER_READBACK_EN to enable SRAM read-back through dout0.
module imem_wb_loader
  import slrv_imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 2 ** IMEM_AW,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  imem_wb_loader_if.slave wb,
  output logic           csb0,
  output logic           web0,
  output logic [3:0]     wmask0,
  output logic [AW-1:0]  addr0,
  output logic [31:0]    din0,
  input  logic [31:0]    dout0,
  output logic           core_reset_o
);

  localparam logic [9:0] CNT_MAX = 10'd1023;

  loader_state_e state;
  logic          ack;
  logic [31:0]   datO;
  logic          coreHold;
  logic [9:0]    wrCnt;
  logic          ctrlWr;
  logic [1:0]    ctrlDat;

  logic [15:0]   off;
  logic          req, sramHit, sramGo, cntInc, cntClr;
  logic [31:0]   regRdata;

  assign off     = wb.wbs_adr_i[15:0];
  assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign sramHit = (off <= SRAM_WIN_END);
`ifdef IMEM_LOADER_READBACK_EN
  assign sramGo  = sramHit;
`else
  assign sramGo  = sramHit & wb.wbs_we_i;
`endif

  // web0/wmask0 still hold the issued command while in SRAM_ACC
  assign cntInc = (state == SRAM_ACC) & ~web0 & (|wmask0);
  assign cntClr = (state == ACK) & ctrlWr & ctrlDat[CTRL_CLR_BIT];

  always_comb begin
    regRdata = '0;
    if (off == CTRL_OFF)
      regRdata[CTRL_HOLD_BIT] = coreHold;
    else if (off == STATUS_OFF)
      regRdata = {15'd0, coreHold, 6'd0, wrCnt};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= IDLE;
      ack      <= 1'b0;
      datO     <= '0;
      csb0     <= 1'b1;
      web0     <= 1'b1;
      wmask0   <= '0;
      addr0    <= '0;
      din0     <= '0;
      coreHold <= 1'b1;
      wrCnt    <= '0;
      ctrlWr   <= 1'b0;
      ctrlDat  <= '0;
    end else begin
      if (cntClr)
        wrCnt <= '0;
      else if (cntInc && wrCnt != CNT_MAX)
        wrCnt <= wrCnt + 10'd1;

      case (state)
        IDLE: begin
          if (req) begin
            if (sramGo) begin
              state  <= SRAM_ACC;
              csb0   <= 1'b0;
              web0   <= ~wb.wbs_we_i;
              wmask0 <= wb.wbs_sel_i;
              addr0  <= wb.wbs_adr_i[AW+1:2];
              din0   <= wb.wbs_dat_i;
            end else begin
              state   <= ACK;
              ack     <= 1'b1;
              datO    <= sramHit ? 32'd0 : regRdata;
              ctrlWr  <= wb.wbs_we_i & (off == CTRL_OFF);
              ctrlDat <= wb.wbs_dat_i[1:0];
            end
          end
        end
        SRAM_ACC: begin
          // the SRAM has sampled the command by now; a dropped cycle leaves a write in place
          csb0 <= 1'b1;
          web0 <= 1'b1;
          if (!wb.wbs_cyc_i)
            state <= IDLE;
`ifdef IMEM_LOADER_READBACK_EN
          else if (web0)
            state <= RD_WAIT;
`endif
          else begin
            state <= ACK;
            ack   <= 1'b1;
            datO  <= '0;
          end
        end
`ifdef IMEM_LOADER_READBACK_EN
        RD_WAIT: begin
          if (!wb.wbs_cyc_i)
            state <= IDLE;
          else begin
            state <= ACK;
            ack   <= 1'b1;
            datO  <= dout0;
          end
        end
`endif
        ACK: begin
          state  <= IDLE;
          ack    <= 1'b0;
          datO   <= '0;
          ctrlWr <= 1'b0;
          if (ctrlWr)
            coreHold <= ctrlDat[CTRL_HOLD_BIT];
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.wbs_ack_o = ack;
  assign wb.wbs_dat_o = datO;
  assign core_reset_o = coreHold;

  logic unusedAdr;
  assign unusedAdr = ^wb.wbs_adr_i[1:0];
`ifndef IMEM_LOADER_READBACK_EN
  logic unusedDout;
  assign unusedDout = ^dout0;
`endif

endmodule
